// File: rtl/gpiov2_pad_ctrl.sv
// Purpose : core-side controller for one sky130 gpiov2 pad: serial config (shadow/active),
//           power-up sequencing of ENABLE_* / HLD_H_N, freeze/hold handling.
// Latency : config visible at pad pins on the SER_LOAD edge; HLD_H_N releases PWR_DLY edges after ENABLE_H.
// Backpr. : none; SER_SHIFT/SER_LOAD/FREEZE are sampled every cycle, no handshake.
// Ports   : CLK/RESET (async active-high); SER_IN/SER_SHIFT/SER_LOAD/SER_OUT serial chain;
//           FREEZE hold request; USER_OUT/USER_OE_N/USER_IN core side; PAD_IN, OUT, OE_N, DM and
//           static config pins to the pad; ENABLE_*, HLD_H_N pad power controls; READY = running.
// Option  : define GPIOV2_IN_SYNC_EN to pass PAD_IN through a 2-flop synchronizer before USER_IN.
module gpiov2_pad_ctrl #(
  parameter logic [12:0] CFG_DEFAULT = 13'h0801,
  parameter int unsigned PWR_DLY     = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SER_IN,
  input  logic       SER_SHIFT,
  input  logic       SER_LOAD,
  output logic       SER_OUT,
  input  logic       FREEZE,
  input  logic       USER_OUT,
  input  logic       USER_OE_N,
  output logic       USER_IN,
  input  logic       PAD_IN,
  output logic       OUT,
  output logic       OE_N,
  output logic [2:0] DM,
  output logic       INP_DIS,
  output logic       IB_MODE_SEL,
  output logic       VTRIP_SEL,
  output logic       SLOW,
  output logic       HLD_OVR,
  output logic       ANALOG_EN,
  output logic       ANALOG_SEL,
  output logic       ANALOG_POL,
  output logic       HLD_H_N,
  output logic       ENABLE_H,
  output logic       ENABLE_INP_H,
  output logic       ENABLE_VDDA_H,
  output logic       ENABLE_VSWITCH_H,
  output logic       ENABLE_VDDIO,
  output logic       READY
);

  localparam int unsigned CFG_W = 13;
  localparam logic [CNT_W-1:0] PWR_DLY_C = CNT_W'(PWR_DLY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ENA  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  logic [CFG_W-1:0] shadow;
  logic [CFG_W-1:0] active;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ena_r;
  logic             hld_n_r;

  // Shadow/active config. Load reads the pre-shift shadow, so a simultaneous
  // shift+load captures the old contents and still advances the chain.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow <= CFG_DEFAULT;
      active <= CFG_DEFAULT;
    end else begin
      if (SER_LOAD)  active <= shadow;
      if (SER_SHIFT) shadow <= {SER_IN, shadow[CFG_W-1:1]};
    end
  end

  // shadow[0] is already a flop, so the chain output is registered.
  assign SER_OUT = shadow[0];

  // Power-up / hold sequencer. Outputs are registered alongside the state so
  // they change on the same edge as the state they belong to.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= ST_OFF;
      cnt     <= '0;
      ena_r   <= 1'b0;
      hld_n_r <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          state   <= ST_ENA;
          cnt     <= PWR_DLY_C;
          ena_r   <= 1'b1;
          hld_n_r <= 1'b0;
        end
        ST_ENA: begin
          // FREEZE is deliberately ignored until the pad is fully powered.
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state   <= ST_RUN;
            hld_n_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (FREEZE) begin
            state   <= ST_HOLD;
            hld_n_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!FREEZE) begin
            state   <= ST_RUN;
            hld_n_r <= 1'b1;
          end
        end
        default: begin
          state   <= ST_OFF;
          ena_r   <= 1'b0;
          hld_n_r <= 1'b0;
        end
      endcase
    end
  end

  assign ENABLE_H         = ena_r;
  assign ENABLE_INP_H     = ena_r;
  assign ENABLE_VDDA_H    = ena_r;
  assign ENABLE_VSWITCH_H = ena_r;
  assign ENABLE_VDDIO     = ena_r;
  assign HLD_H_N          = hld_n_r;
  assign READY            = (state == ST_RUN);

  // Static pad configuration straight from the active register.
  assign DM          = active[2:0];
  assign VTRIP_SEL   = active[3];
  assign SLOW        = active[4];
  assign IB_MODE_SEL = active[5];
  assign INP_DIS     = active[6];
  assign HLD_OVR     = active[7];
  assign ANALOG_EN   = active[8];
  assign ANALOG_SEL  = active[9];
  assign ANALOG_POL  = active[10];

  // Output driver stays off until the pad supplies are up.
  assign OE_N = USER_OE_N | active[11] | (state == ST_OFF) | (state == ST_ENA);
  assign OUT  = USER_OUT ^ active[12];

`ifdef GPIOV2_IN_SYNC_EN
  logic [1:0] in_sync;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) in_sync <= 2'b00;
    else       in_sync <= {in_sync[0], PAD_IN};
  end
  assign USER_IN = in_sync[1];
`else
  assign USER_IN = PAD_IN;
`endif

endmodule

// File: doc/gpiov2_pad_ctrl.md
Name: gpiov2_pad_ctrl

Overview:
Core-side controller that drives the control pins of one sky130 gpiov2 pad wrapper. It is the logic that sits opposite the pad's control inputs. Pad configuration is loaded through a daisy-chainable serial shift register with a shadow/active split. A power-up FSM sequences the ENABLE_* signals and HLD_H_N, and supports a freeze/hold request. One instance is used per I/O pad in the padframe.

Parameters:
CFG_DEFAULT, 13'h0801, reset value of the shadow and active config: DM=3'b001, input enabled, OE forced off.
PWR_DLY, 16, cycles from ENABLE_H assertion to HLD_H_N release; legal range 1..2^CNT_W-1.
CNT_W, 8, width of the power-up delay counter.

Ports:
CLK  input  1  core clock
RESET  input  1  asynchronous, active-high reset
SER_IN  input  1  serial config data in
SER_SHIFT  input  1  shift enable
SER_LOAD  input  1  copy shadow to active
SER_OUT  output  1  serial data out (shadow[0]) for daisy chain
FREEZE  input  1  request pad hold
USER_OUT  input  1  core output data
USER_OE_N  input  1  core output enable, active-low
USER_IN  output  1  pad input data to core
PAD_IN  input  1  IN pin of pad
OUT  output  1  to pad OUT
OE_N  output  1  to pad OE_N
DM  output  3  to pad DM
INP_DIS, IB_MODE_SEL, VTRIP_SEL, SLOW, HLD_OVR, ANALOG_EN, ANALOG_SEL, ANALOG_POL  output  1 each  to pad
HLD_H_N  output  1  to pad, active-low hold
ENABLE_H, ENABLE_INP_H, ENABLE_VDDA_H, ENABLE_VSWITCH_H, ENABLE_VDDIO  output  1 each  to pad
READY  output  1  high in RUN state

Behaviour:
- Config bit map (CFG_W=13): [2:0] DM, [3] VTRIP_SEL, [4] SLOW, [5] IB_MODE_SEL, [6] INP_DIS, [7] HLD_OVR, [8] ANALOG_EN, [9] ANALOG_SEL, [10] ANALOG_POL, [11] OE_FORCE_OFF, [12] OUT_INV.
- Shift: when SER_SHIFT=1, at the clock edge shadow <= {SER_IN, shadow[12:1]}. Data is LSB-first: the first bit shifted in reaches bit 0 after 13 shifts. SER_OUT = shadow[0], registered.
- Load: when SER_LOAD=1, at the clock edge active <= shadow. If SER_SHIFT and SER_LOAD are high in the same cycle, active takes the pre-shift shadow and the shift still occurs.
- DM, VTRIP_SEL, SLOW, IB_MODE_SEL, INP_DIS, HLD_OVR and ANALOG_* are driven directly from the active register, with no added latency beyond the load edge.
- FSM states: OFF, ENA, RUN, HOLD.
  - OFF -> ENA on the first clock edge after RESET is deasserted; the counter is loaded with PWR_DLY.
  - ENA: counter decrements each cycle; at 1 -> RUN.
  - RUN: FREEZE=1 -> HOLD.
  - HOLD: FREEZE=0 -> RUN.
- ENABLE_H, ENABLE_INP_H, ENABLE_VDDA_H, ENABLE_VSWITCH_H and ENABLE_VDDIO are registered: 0 in OFF, 1 in ENA/RUN/HOLD.
- HLD_H_N is registered: 1 only in RUN. READY = (state==RUN).
- Timing: ENABLE_H rises at edge 1 after reset release. HLD_H_N rises PWR_DLY edges later.
- OE_N = USER_OE_N | active[11] | (state is OFF or ENA). OUT = USER_OUT ^ active[12].
- RESET high (async, including mid-shift or mid-ENA):
  - shadow and active = CFG_DEFAULT, state = OFF, counter = 0;
  - all ENABLE_* = 0, HLD_H_N = 0, READY = 0, SER_OUT = CFG_DEFAULT[0].
- FREEZE asserted during ENA is ignored until RUN is reached; RUN is then exited to HOLD on the next edge.
- Loads are accepted in every state. In HOLD the pad latches its outputs, so a new config takes effect at the pad only after return to RUN.

Optional Feature:
GPIOV2_IN_SYNC_EN
- Defined: PAD_IN passes through a 2-flop synchronizer (reset value 0), so USER_IN lags PAD_IN by 2 edges.
- Undefined: USER_IN = PAD_IN, combinational.

Test Plan:
- Power-up: release RESET with PWR_DLY=4 -> ENABLE_H=1 at edge 1, HLD_H_N=1 and READY=1 at edge 5; OE_N=1 throughout.
- Shift 13 bits of 13'h1006 LSB-first, then pulse SER_LOAD -> DM=3'b110, OE_FORCE_OFF=0, OUT_INV=1; with USER_OUT=1 and USER_OE_N=0 -> OUT=0, OE_N=0.
- Daisy chain: after 13 shifts, SER_OUT emits the CFG_DEFAULT bits in order 1,0,0,0,0,0,0,0,0,0,0,1,0.
- Simultaneous SER_SHIFT and SER_LOAD with shadow=13'h0AAA -> active=13'h0AAA, shadow shifted once.
- FREEZE pulse of 3 cycles in RUN -> HLD_H_N=0 and READY=0 for 3 cycles, then 1; asserting RESET mid-ENA -> all outputs return to reset values immediately.
- With GPIOV2_IN_SYNC_EN defined: PAD_IN 0->1 -> USER_IN=1 two edges later. Without it: same cycle.
